slice_tx: RTL and testbench

Word-to-slice transmitter. Accepts a `WORD_W`-bit word over a valid/ready handshake and emits it as consecutive 3-bit slices on a `data[2:0]` bus, with its own valid/ready handshake and a last-slice marker. It is the producing end that drives the 3-bit `data` input of downstream slice consumers. It sits between a word-wide source and any block taking a 3-bit `data` bus.

---
 rtl/slice_tx.sv | 92 +++++++++
 tb/tb_slice_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/slice_tx.sv
// Word-to-slice transmitter: serialises a WORD_W-bit word LSB-first into 3-bit slices.
// Slice 0 is valid the cycle after word accept; SLICE_TX_BACK2BACK_EN removes the inter-word IDLE bubble.
module slice_tx #(
  parameter int WORD_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic [2:0]        data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              data_last
);

  localparam int NSLICE = WORD_W / 3;
  localparam int CNT_W  = $clog2(NSLICE);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic              idle_rdy;
  logic              dv_q;
  logic              dl_q;
  logic              accept;
  logic              xfer;

  assign data       = shreg[2:0];
  assign data_valid = dv_q;
  assign data_last  = dl_q;

`ifdef SLICE_TX_BACK2BACK_EN
  assign in_ready = idle_rdy | (dl_q & data_ready);
`else
  assign in_ready = idle_rdy;
`endif

  assign accept = in_valid & in_ready;
  assign xfer   = dv_q & data_ready;

  // idle_rdy is a registered IDLE decode; it stays low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      idle_rdy <= 1'b0;
      dv_q     <= 1'b0;
      dl_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          idle_rdy <= 1'b1;
          if (accept) begin
            shreg    <= in_word;
            cnt      <= '0;
            state    <= SEND;
            dv_q     <= 1'b1;
            dl_q     <= 1'b0;
            idle_rdy <= 1'b0;
          end
        end
        SEND: begin
          if (xfer) begin
            if (!dl_q) begin
              shreg <= shreg >> 3;
              cnt   <= cnt + 1'b1;
              dl_q  <= (cnt == CNT_W'(NSLICE - 2));
            end else if (accept) begin
              // only reachable with back-to-back enabled: reload without passing through IDLE
              shreg <= in_word;
              cnt   <= '0;
              dl_q  <= 1'b0;
            end else begin
              state    <= IDLE;
              shreg    <= '0;
              cnt      <= '0;
              dv_q     <= 1'b0;
              dl_q     <= 1'b0;
              idle_rdy <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slice_tx.sv
// Directed bench for slice_tx (WORD_W=12); expected slices derived from in_word[3i+2:3i].
module tb_slice_tx;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_word;
  logic [2:0]  data;
  logic        data_valid;
  logic        data_ready;
  logic        data_last;

  int total;
  int bad;

  slice_tx #(.WORD_W(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_last  (data_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] slc(input logic [11:0] w, input int i);
    return w[3*i +: 3];
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one word for a single edge, then check all four slices with data_ready held high.
  task automatic send_word(input logic [11:0] w, input string tag);
    in_word    = w;
    in_valid   = 1'b1;
    data_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_dv%0d", tag, i), 12'(data_valid), 12'd1);
      chk($sformatf("%s_data%0d", tag, i), 12'(data), 12'(slc(w, i)));
      chk($sformatf("%s_last%0d", tag, i), 12'(data_last), 12'(i == 3));
      @(negedge clk);
    end
    chk({tag, "_idle_dv"}, 12'(data_valid), 12'd0);
    chk({tag, "_idle_rdy"}, 12'(in_ready), 12'd1);
  endtask

  initial begin
    logic [11:0] w;
    int          nb;
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_word    = 12'h0;
    data_ready = 1'b0;

    // Reset state while asserted
    #3;
    chk("rst_dv", 12'(data_valid), 12'd0);
    chk("rst_data", 12'(data), 12'd0);
    chk("rst_last", 12'(data_last), 12'd0);
    chk("rst_rdy", 12'(in_ready), 12'd0);
    #4 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_rdy", 12'(in_ready), 12'd1);
    chk("post_rst_dv", 12'(data_valid), 12'd0);

    // Single word
    send_word(12'hABC, "single");

    // Backpressure on slice 1
    in_word    = 12'hABC;
    in_valid   = 1'b1;
    data_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_s0", 12'(data), 12'd4);
    @(negedge clk);
    chk("bp_s1", 12'(data), 12'd7);
    data_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_data%0d", i), 12'(data), 12'd7);
      chk($sformatf("bp_hold_dv%0d", i), 12'(data_valid), 12'd1);
      chk($sformatf("bp_hold_last%0d", i), 12'(data_last), 12'd0);
    end
    data_ready = 1'b1;
    @(negedge clk);
    chk("bp_s2", 12'(data), 12'd2);
    @(negedge clk);
    chk("bp_s3", 12'(data), 12'd5);
    chk("bp_s3_last", 12'(data_last), 12'd1);
    @(negedge clk);
    chk("bp_end_dv", 12'(data_valid), 12'd0);

    // Back-to-back: 12'h111 then 12'hFFF offered continuously
    in_word  = 12'h111;
    in_valid = 1'b1;
    @(negedge clk);
    in_word = 12'hFFF;
`ifdef SLICE_TX_BACK2BACK_EN
    nb = 8;
`else
    nb = 9;
`endif
    for (int c = 0; c < nb; c++) begin
      if (c < 4) begin
        chk($sformatf("b2b_dv%0d", c), 12'(data_valid), 12'd1);
        chk($sformatf("b2b_data%0d", c), 12'(data), 12'(slc(12'h111, c)));
      end else if (nb == 9 && c == 4) begin
        chk("b2b_gap_dv", 12'(data_valid), 12'd0);
      end else begin
        chk($sformatf("b2b_dv%0d", c), 12'(data_valid), 12'd1);
        chk($sformatf("b2b_data%0d", c), 12'(data), 12'(slc(12'hFFF, c - (nb - 4))));
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_end_dv", 12'(data_valid), 12'd0);

    // Reset mid-word after slice 1
    in_word  = 12'hABC;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_s0", 12'(data), 12'd4);
    @(negedge clk);
    chk("mid_s1", 12'(data), 12'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_dv", 12'(data_valid), 12'd0);
    chk("mid_rst_data", 12'(data), 12'd0);
    chk("mid_rst_last", 12'(data_last), 12'd0);
    chk("mid_rst_rdy", 12'(in_ready), 12'd0);
    #4 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rel_rdy", 12'(in_ready), 12'd1);
    send_word(12'h000, "zero");

    // Input ignored while busy
    w          = 12'h5A3;
    in_word    = w;
    in_valid   = 1'b1;
    data_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_word = 12'($urandom);
      if (i == 3) in_valid = 1'b0;
      #1;
      chk($sformatf("busy_data%0d", i), 12'(data), 12'(slc(w, i)));
`ifdef SLICE_TX_BACK2BACK_EN
      chk($sformatf("busy_rdy%0d", i), 12'(in_ready), 12'(i == 3));
`else
      chk($sformatf("busy_rdy%0d", i), 12'(in_ready), 12'd0);
`endif
      @(negedge clk);
    end
    chk("busy_end_dv", 12'(data_valid), 12'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
